// File: rtl/init_command_sequencer.sv
// Initialization/command sequencer: decodes ICW1..ICW4 and OCW1..OCW3 writes and commits each one when the write strobe ends.
// Optional cascade support (ICW3 / WAIT_ICW3) is enabled by defining INIT_SEQ_CASCADE_EN.
module init_command_sequencer (
  input  logic       clk,
  input  logic       reset_bar,
  input  logic       CS_bar,
  input  logic       WR_bar,
  input  logic       A0,
  input  logic [7:0] data_bus_in,
  output logic       init_done,
  output logic       ltim,
  output logic       sngl,
  output logic [4:0] vector_base,
  output logic [7:0] cascade_cfg,
  output logic       aeoi,
  output logic [7:0] imr,
  output logic       ocw2_strobe,
  output logic [7:0] ocw2_data,
  output logic       read_isr,
  output logic       smm,
  output logic       poll_strobe
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_ICW2 = 3'd1,
    WAIT_ICW3 = 3'd2,
    WAIT_ICW4 = 3'd3,
    READY     = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic       wr_active;
  logic       commit;
  logic       wr_active_q;
  logic       lat_a0_q, lat_a0_d;
  logic [7:0] lat_d_q, lat_d_d;
  logic       ltim_q, ltim_d;
  logic       sngl_q, sngl_d;
  logic       ic4_q, ic4_d;
  logic [4:0] vector_base_q, vector_base_d;
  logic [7:0] cascade_cfg_q, cascade_cfg_d;
  logic       aeoi_q, aeoi_d;
  logic [7:0] imr_q, imr_d;
  logic       ocw2_strobe_q, ocw2_strobe_d;
  logic [7:0] ocw2_data_q, ocw2_data_d;
  logic       read_isr_q, read_isr_d;
  logic       smm_q, smm_d;
  logic       poll_strobe_q, poll_strobe_d;
  logic       sngl_eff;

  assign wr_active = ~CS_bar & ~WR_bar;
  // A commit is the falling edge of wr_active, whichever of CS_bar/WR_bar ended it.
  assign commit    = wr_active_q & ~wr_active;

`ifdef INIT_SEQ_CASCADE_EN
  assign sngl_eff = sngl_q;
`else
  assign sngl_eff = 1'b1;
`endif

  always_comb begin
    state_d       = state_q;
    lat_a0_d      = wr_active ? A0 : lat_a0_q;
    lat_d_d       = wr_active ? data_bus_in : lat_d_q;
    ltim_d        = ltim_q;
    sngl_d        = sngl_q;
    ic4_d         = ic4_q;
    vector_base_d = vector_base_q;
    cascade_cfg_d = cascade_cfg_q;
    aeoi_d        = aeoi_q;
    imr_d         = imr_q;
    ocw2_strobe_d = 1'b0;
    ocw2_data_d   = ocw2_data_q;
    read_isr_d    = read_isr_q;
    smm_d         = smm_q;
    poll_strobe_d = 1'b0;
    if (commit) begin
      if (!lat_a0_q && lat_d_q[4]) begin
        // ICW1 restarts initialization from any state.
        ltim_d        = lat_d_q[3];
        sngl_d        = lat_d_q[1];
        ic4_d         = lat_d_q[0];
        imr_d         = 8'h00;
        read_isr_d    = 1'b0;
        smm_d         = 1'b0;
        aeoi_d        = 1'b0;
        cascade_cfg_d = 8'h00;
        state_d       = WAIT_ICW2;
      end else begin
        case (state_q)
          WAIT_ICW2: if (lat_a0_q) begin
            vector_base_d = lat_d_q[7:3];
            if (!sngl_eff)  state_d = WAIT_ICW3;
            else if (ic4_q) state_d = WAIT_ICW4;
            else            state_d = READY;
          end
`ifdef INIT_SEQ_CASCADE_EN
          WAIT_ICW3: if (lat_a0_q) begin
            cascade_cfg_d = lat_d_q;
            state_d       = ic4_q ? WAIT_ICW4 : READY;
          end
`endif
          WAIT_ICW4: if (lat_a0_q) begin
            aeoi_d  = lat_d_q[1];
            state_d = READY;
          end
          READY: begin
            if (lat_a0_q) begin
              imr_d = lat_d_q;
            end else if (!lat_d_q[3]) begin
              ocw2_data_d   = lat_d_q;
              ocw2_strobe_d = 1'b1;
            end else begin
              if (lat_d_q[1]) read_isr_d = lat_d_q[0];
              if (lat_d_q[6]) smm_d = lat_d_q[5];
              poll_strobe_d = lat_d_q[2];
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      state_q       <= IDLE;
      wr_active_q   <= 1'b0;
      lat_a0_q      <= 1'b0;
      lat_d_q       <= 8'h00;
      ltim_q        <= 1'b0;
      sngl_q        <= 1'b0;
      ic4_q         <= 1'b0;
      vector_base_q <= 5'h00;
      cascade_cfg_q <= 8'h00;
      aeoi_q        <= 1'b0;
      imr_q         <= 8'h00;
      ocw2_strobe_q <= 1'b0;
      ocw2_data_q   <= 8'h00;
      read_isr_q    <= 1'b0;
      smm_q         <= 1'b0;
      poll_strobe_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_active_q   <= wr_active;
      lat_a0_q      <= lat_a0_d;
      lat_d_q       <= lat_d_d;
      ltim_q        <= ltim_d;
      sngl_q        <= sngl_d;
      ic4_q         <= ic4_d;
      vector_base_q <= vector_base_d;
      cascade_cfg_q <= cascade_cfg_d;
      aeoi_q        <= aeoi_d;
      imr_q         <= imr_d;
      ocw2_strobe_q <= ocw2_strobe_d;
      ocw2_data_q   <= ocw2_data_d;
      read_isr_q    <= read_isr_d;
      smm_q         <= smm_d;
      poll_strobe_q <= poll_strobe_d;
    end
  end

  assign init_done   = (state_q == READY);
  assign ltim        = ltim_q;
  assign sngl        = sngl_q;
  assign vector_base = vector_base_q;
  assign aeoi        = aeoi_q;
  assign imr         = imr_q;
  assign ocw2_strobe = ocw2_strobe_q;
  assign ocw2_data   = ocw2_data_q;
  assign read_isr    = read_isr_q;
  assign smm         = smm_q;
  assign poll_strobe = poll_strobe_q;
`ifdef INIT_SEQ_CASCADE_EN
  assign cascade_cfg = cascade_cfg_q;
`else
  assign cascade_cfg = 8'h00;
`endif

endmodule

// File: tb/tb_init_command_sequencer.sv
// Directed bench for init_command_sequencer: ICW sequences, OCW1..3 in READY, CS-ended writes, reset mid-write.
module tb_init_command_sequencer;
  logic       clk = 1'b0;
  logic       reset_bar;
  logic       CS_bar, WR_bar, A0;
  logic [7:0] data_bus_in;
  logic       init_done, ltim, sngl, aeoi, ocw2_strobe, read_isr, smm, poll_strobe;
  logic [4:0] vector_base;
  logic [7:0] cascade_cfg, imr, ocw2_data;
  int         n_err = 0;
  int         n_chk = 0;

  init_command_sequencer dut (
    .clk(clk), .reset_bar(reset_bar), .CS_bar(CS_bar), .WR_bar(WR_bar), .A0(A0),
    .data_bus_in(data_bus_in), .init_done(init_done), .ltim(ltim), .sngl(sngl),
    .vector_base(vector_base), .cascade_cfg(cascade_cfg), .aeoi(aeoi), .imr(imr),
    .ocw2_strobe(ocw2_strobe), .ocw2_data(ocw2_data), .read_isr(read_isr), .smm(smm),
    .poll_strobe(poll_strobe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge right after the commit edge.
  task automatic wr(input logic a0, input logic [7:0] d);
    CS_bar = 1'b0; WR_bar = 1'b0; A0 = a0; data_bus_in = d;
    @(negedge clk);
    CS_bar = 1'b1; WR_bar = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    reset_bar = 1'b0; CS_bar = 1'b1; WR_bar = 1'b1; A0 = 1'b0; data_bus_in = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_init_done", {7'd0, init_done}, 8'h00);
    chk("rst_imr", imr, 8'h00);
    chk("rst_vector_base", {3'd0, vector_base}, 8'h00);
    chk("rst_misc", {ltim, sngl, aeoi, ocw2_strobe, read_isr, smm, poll_strobe, 1'b0}, 8'h00);
    reset_bar = 1'b1;
    @(negedge clk);

    // Single mode with ICW4: ICW3 skipped
    wr(1'b0, 8'h13);
    chk("icw1_sngl_ltim", {6'd0, sngl, ltim}, 8'h02);
    chk("icw1_not_done", {7'd0, init_done}, 8'h00);
    wr(1'b1, 8'h48);
    chk("icw2_vector_base", {3'd0, vector_base}, 8'h09);
    chk("icw2_not_done", {7'd0, init_done}, 8'h00);
    wr(1'b1, 8'h03);
    chk("icw4_aeoi", {7'd0, aeoi}, 8'h01);
    chk("icw4_done", {7'd0, init_done}, 8'h01);

    // OCW1 and OCW2
    wr(1'b1, 8'hA5);
    chk("ocw1_imr", imr, 8'hA5);
    wr(1'b0, 8'h20);
    chk("ocw2_strobe_hi", {7'd0, ocw2_strobe}, 8'h01);
    chk("ocw2_data", ocw2_data, 8'h20);
    @(negedge clk);
    chk("ocw2_strobe_lo", {7'd0, ocw2_strobe}, 8'h00);

    // OCW3
    wr(1'b0, 8'h0B);
    chk("ocw3_read_isr", {7'd0, read_isr}, 8'h01);
    chk("ocw3_no_poll", {6'd0, poll_strobe, ocw2_strobe}, 8'h00);
    wr(1'b0, 8'h68);
    chk("ocw3_smm", {6'd0, smm, read_isr}, 8'h03);
    wr(1'b0, 8'h0C);
    chk("ocw3_poll_hi", {6'd0, poll_strobe, ocw2_strobe}, 8'h02);
    chk("ocw3_read_isr_kept", {7'd0, read_isr}, 8'h01);
    chk("ocw3_ocw2_data_kept", ocw2_data, 8'h20);
    @(negedge clk);
    chk("ocw3_poll_lo", {7'd0, poll_strobe}, 8'h00);

    // ICW1 while READY restarts init and clears masks/modes
    wr(1'b0, 8'h13);
    chk("reinit_imr", imr, 8'h00);
    chk("reinit_flags", {5'd0, init_done, read_isr, smm}, 8'h00);
    wr(1'b0, 8'h20);
    chk("wait_icw2_ignore_a0lo", {6'd0, ocw2_strobe, init_done}, 8'h00);
    wr(1'b1, 8'hF8);
    chk("reinit_vector_base", {3'd0, vector_base}, 8'h1F);
    wr(1'b1, 8'h00);
    chk("reinit_done", {6'd0, init_done, aeoi}, 8'h02);

    // Cascade sequence
    wr(1'b0, 8'h11);
    chk("casc_icw1", {6'd0, sngl, ltim}, 8'h00);
    wr(1'b1, 8'h20);
    chk("casc_vector_base", {3'd0, vector_base}, 8'h04);
    wr(1'b1, 8'h04);
`ifdef INIT_SEQ_CASCADE_EN
    chk("casc_third_done", {7'd0, init_done}, 8'h00);
    wr(1'b1, 8'h01);
    chk("casc_cfg", cascade_cfg, 8'h04);
    chk("casc_imr", imr, 8'h00);
`else
    chk("casc_third_done", {7'd0, init_done}, 8'h01);
    wr(1'b1, 8'h01);
    chk("casc_cfg", cascade_cfg, 8'h00);
    chk("casc_imr", imr, 8'h01);
`endif
    chk("casc_done_aeoi", {6'd0, init_done, aeoi}, 8'h02);

    // Write ended by CS_bar rising while WR_bar stays low
    CS_bar = 1'b0; WR_bar = 1'b0; A0 = 1'b1; data_bus_in = 8'h5A;
    @(negedge clk);
    CS_bar = 1'b1;
    @(negedge clk);
    WR_bar = 1'b1;
    chk("cs_rise_commit_imr", imr, 8'h5A);
    @(negedge clk);

    // Reset in the middle of an ICW1 write
    CS_bar = 1'b0; WR_bar = 1'b0; A0 = 1'b0; data_bus_in = 8'h13;
    @(negedge clk);
    reset_bar = 1'b0;
    #1;
    chk("async_rst_imr", imr, 8'h00);
    chk("async_rst_flags", {init_done, sngl, aeoi, read_isr, smm, 3'd0}, 8'h00);
    chk("async_rst_vector_base", {3'd0, vector_base}, 8'h00);
    @(negedge clk);
    CS_bar = 1'b1; WR_bar = 1'b1;
    @(negedge clk);
    reset_bar = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_discard_sngl", {6'd0, sngl, init_done}, 8'h00);
    chk("rst_discard_ocw2", {6'd0, ocw2_strobe, poll_strobe}, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/init_command_sequencer.md
INIT_COMMAND_SEQUENCER -- requirements
Module: init_command_sequencer

Interface
REQ-001 The block SHALL have these ports:
- clk  input  1  single clock; all state changes on its rising edge.
- reset_bar  input  1  asynchronous, active-low reset.
- CS_bar  input  1  chip select, active low.
- WR_bar  input  1  write enable, active low.
- A0  input  1  command-word address bit.
- data_bus_in  input  8  write data.
- init_done  output  1  high in state READY.
- ltim  output  1  ICW1 D3 (level-triggered mode).
- sngl  output  1  ICW1 D1 (single mode).
- vector_base  output  5  ICW2 D7..D3.
- cascade_cfg  output  8  ICW3 value.
- aeoi  output  1  ICW4 D1.
- imr  output  8  OCW1 interrupt mask.
- ocw2_strobe  output  1  one-cycle pulse on an OCW2 commit.
- ocw2_data  output  8  last OCW2 byte.
- read_isr  output  1  read select: 0 = IRR, 1 = ISR.
- smm  output  1  special mask mode.
- poll_strobe  output  1  one-cycle pulse on an OCW3 commit with D2=1.

Function
REQ-002 wr_active SHALL equal ~CS_bar & ~WR_bar, sampled each clk; while it is 1, the block SHALL latch A0 and data_bus_in into lat_a0 and lat_d.
REQ-003 A commit SHALL occur on the first clk edge where the registered wr_active was 1 and the current wr_active is 0; all register updates SHALL take effect at that edge, using lat_a0 and lat_d.
REQ-004 States SHALL be IDLE, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4 and READY, state-encoded, with one transition at most per commit.
REQ-005 ICW1 (lat_a0=0, lat_d[4]=1) SHALL be accepted in every state with these actions:
- capture ltim, sngl and the ic4 bit (D0);
- clear imr, read_isr, smm, aeoi, cascade_cfg;
- go to WAIT_ICW2.
REQ-006 In WAIT_ICW2, a commit with lat_a0=1 SHALL load vector_base=lat_d[7:3] and go to: WAIT_ICW3 if sngl=0, else WAIT_ICW4 if ic4=1, else READY.
REQ-007 In WAIT_ICW3, a commit with lat_a0=1 SHALL load cascade_cfg and go to WAIT_ICW4 if ic4=1, else READY.
REQ-008 In WAIT_ICW4, a commit with lat_a0=1 SHALL load aeoi=lat_d[1] and go to READY.
REQ-009 In the WAIT_* states, lat_a0=0 writes with lat_d[4]=0 SHALL be ignored. In IDLE, all non-ICW1 writes SHALL be ignored.
REQ-010 In READY, commits SHALL be handled as follows:
- lat_a0=1: imr=lat_d.
- lat_a0=0, d4=0, d3=0: ocw2_data=lat_d, and ocw2_strobe=1 for exactly one cycle.
- lat_a0=0, d4=0, d3=1 (OCW3):
  - if d1=1, read_isr=d0;
  - if d6=1, smm=d5;
  - if d2=1, poll_strobe=1 for one cycle.
REQ-011 Strobes SHALL be 0 in every cycle other than the commit cycle. Back-to-back writes separated by one inactive cycle SHALL each commit.
REQ-012 RD_bar SHALL NOT affect this block. If CS_bar rises while WR_bar is low, that SHALL count as a commit (wr_active fell).

Reset
REQ-013 reset_bar=0 SHALL asynchronously force:
- state=IDLE;
- wr_active register, lat_a0 and lat_d to 0;
- all outputs to 0 (imr=8'h00, vector_base=5'h00).
REQ-014 A reset during an active write SHALL discard that write; no commit SHALL occur on reset release, even if wr_active is 1 then.

Configuration
REQ-015 Macro INIT_SEQ_CASCADE_EN SHALL control cascade support:
- Defined: cascade as specified above.
- Undefined:
  - WAIT_ICW3 SHALL be unreachable, and sngl SHALL be treated as 1 in the REQ-006 transition;
  - the sngl output SHALL still reflect ICW1 D1;
  - cascade_cfg SHALL be tied to 8'h00.

Verification
REQ-016 ICW1=8'h13, ICW2=8'h48, ICW4=8'h03 -> vector_base=5'h09, aeoi=1, init_done=1 one edge after the third commit; WAIT_ICW3 never entered.
REQ-017 With the macro defined: ICW1=8'h11, ICW2=8'h20, ICW3=8'h04, ICW4=8'h01 -> cascade_cfg=8'h04, aeoi=0, READY. Without the macro, the same sequence -> ICW3 byte taken as ICW4, aeoi=0, cascade_cfg=8'h00.
REQ-018 In READY: A0=1 write of 8'hA5 -> imr=8'hA5. Then A0=0 write of 8'h20 -> ocw2_strobe high exactly one cycle, ocw2_data=8'h20.
REQ-019 In READY: OCW3=8'h0B -> read_isr=1. OCW3=8'h68 -> smm=1. OCW3=8'h0C -> poll_strobe pulse, read_isr unchanged.
REQ-020 In READY: ICW1=8'h13 -> imr=8'h00, init_done=0, state WAIT_ICW2. Separately, reset_bar low mid-write -> all outputs 0, no commit after release.
